payload_byte_feeder: RTL and testbench

- Front end that drives the payload regex engines.
- Accepts packet payload as 64-bit words on a valid/ready stream and serializes them into one byte per clock.
- Produces the per-byte strobe `en`, the start-of-data clear pulse `sod`, and the case-folded byte that the character-class decoder expands into the engines' `in_N` lines.
- Signals end of data so match outputs can be sampled and collected per packet.

---
 rtl/payload_byte_feeder_if.sv | 13 +
 rtl/payload_byte_feeder.sv | 134 +++++++++++++
 tb/tb_payload_byte_feeder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/payload_byte_feeder_if.sv
// payload_byte_feeder_if: payload word stream (s_data/s_keep/s_last/s_valid in, s_ready back)
interface payload_byte_feeder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic [KEEP_WIDTH-1:0] s_keep;
  logic                  s_last;
  logic                  s_valid;
  logic                  s_ready;
  modport master (output s_data, s_keep, s_last, s_valid, input s_ready);
  modport slave  (input s_data, s_keep, s_last, s_valid, output s_ready);
endinterface

// File: rtl/payload_byte_feeder.sv
// payload_byte_feeder: serializes payload words (s stream) into one byte/clk on char_out/en with sod/eod pulses and pkt_len
module payload_byte_feeder #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int CASE_FOLD  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  payload_byte_feeder_if.slave s,
  output logic                 sod,
  output logic                 en,
  output logic                 eod,
  output logic [7:0]           char_out,
  output logic [CNT_WIDTH-1:0] pkt_len
);
  localparam int PW = $clog2(KEEP_WIDTH + 1);
  localparam int IW = $clog2(DATA_WIDTH / 8);
  typedef enum logic [2:0] {IDLE, SOD, STREAM, FETCH, EOD} state_t;
  state_t                          state_q, state_d;
  logic [DATA_WIDTH/8-1:0][7:0]    word_q, word_d;
  logic [PW-1:0]                   n_q, n_d, pos_q, pos_d, in_n, e_pos, e_n;
  logic                            last_q, last_d, sod_q, sod_d, en_q, en_d, eod_q, eod_d, rdy_q, rdy_d;
  logic [7:0]                      char_q, char_d, e_byte;
  logic [CNT_WIDTH-1:0]            cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic                            acc, have_buf, buf_done_last, e_last, emit, to_eod;
  function automatic logic [PW-1:0] lanes(input logic [KEEP_WIDTH-1:0] k);
    logic [PW-1:0] n;
    logic          stop;
    n = '0;
    stop = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      if (!stop && k[i]) n = n + PW'(1);
      else stop = 1'b1;
    return n;
  endfunction
  function automatic logic [7:0] fold(input logic [7:0] b);
    return (CASE_FOLD != 0 && b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
  endfunction
  always_comb begin
    acc           = rdy_q & s.s_valid;
    in_n          = lanes(s.s_keep);
    cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    // only SOD/STREAM hold a buffered word whose flags are meaningful
    have_buf      = (state_q == SOD || state_q == STREAM) && pos_q != n_q;
    buf_done_last = (state_q == SOD || state_q == STREAM) && pos_q == n_q && last_q;
    e_byte        = have_buf ? word_q[pos_q[IW-1:0]] : s.s_data[7:0];
    e_pos         = have_buf ? pos_q : '0;
    e_n           = have_buf ? n_q : in_n;
    e_last        = have_buf ? last_q : s.s_last;
    emit          = have_buf || (!buf_done_last && acc && in_n != '0);
    to_eod        = !have_buf && (buf_done_last || (acc && in_n == '0 && s.s_last));
    state_d = state_q;
    word_d  = word_q;
    n_d     = n_q;
    pos_d   = pos_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    char_d  = char_q;
    sod_d   = 1'b0;
    en_d    = 1'b0;
    eod_d   = 1'b0;
    rdy_d   = 1'b0;
    if (acc) begin
      word_d = s.s_data;
      n_d    = in_n;
      last_d = s.s_last;
      pos_d  = '0;
    end
    case (state_q)
      IDLE, EOD: begin
        rdy_d   = !acc;
        sod_d   = acc;
        state_d = acc ? SOD : IDLE;
        cnt_d   = acc ? '0 : cnt_q;
      end
      default: begin
        if (emit) begin
          state_d = STREAM;
          en_d    = 1'b1;
          char_d  = fold(e_byte);
          pos_d   = e_pos + PW'(1);
          cnt_d   = cnt_inc;
          // open the input while the word's final byte is on char_out so the next word follows without a bubble
          rdy_d   = (e_pos + PW'(1) == e_n) && !e_last;
        end else if (to_eod) begin
          state_d = EOD;
          eod_d   = 1'b1;
          len_d   = cnt_q;
          rdy_d   = 1'b1;
        end else begin
          state_d = FETCH;
          rdy_d   = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      n_q     <= '0;
      pos_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      char_q  <= '0;
      sod_q   <= 1'b0;
      en_q    <= 1'b0;
      eod_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      n_q     <= n_d;
      pos_q   <= pos_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      char_q  <= char_d;
      sod_q   <= sod_d;
      en_q    <= en_d;
      eod_q   <= eod_d;
      rdy_q   <= rdy_d;
    end
  end
  assign s.s_ready = rdy_q;
  assign sod       = sod_q;
  assign en        = en_q;
  assign eod       = eod_q;
  assign char_out  = char_q;
  assign pkt_len   = len_q;
endmodule

// File: tb/tb_payload_byte_feeder.sv
// tb_payload_byte_feeder: directed checks of payload_byte_feeder with folding and non-folding instances
module tb_payload_byte_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  payload_byte_feeder_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) if0 ();
  payload_byte_feeder_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) if1 ();
  logic        sod0, en0, eod0, sod1, en1, eod1;
  logic [7:0]  ch0, ch1;
  logic [15:0] len0, len1;
  payload_byte_feeder #(.CASE_FOLD(1)) dut0 (.clk(clk), .rst(rst), .s(if0.slave), .sod(sod0), .en(en0), .eod(eod0), .char_out(ch0), .pkt_len(len0));
  payload_byte_feeder #(.CASE_FOLD(0)) dut1 (.clk(clk), .rst(rst), .s(if1.slave), .sod(sod1), .en(en1), .eod(eod1), .char_out(ch1), .pkt_len(len1));
  int errs = 0, checks = 0;
  int cyc = 0, sods, eods, ens, ovl, en_first, en_last, sod_c, eod_c;
  logic [7:0] b0[$], b1[$];
  int lens[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (sod0 && en0) ovl++;
    if (sod0) begin sods++; sod_c = cyc; end
    if (en0) begin
      ens++;
      b0.push_back(ch0);
      if (en_first < 0) en_first = cyc;
      en_last = cyc;
    end
    if (en1) b1.push_back(ch1);
    if (eod0) begin eods++; eod_c = cyc; lens.push_back(int'(len0)); end
  end
  task automatic clear();
    sods = 0; eods = 0; ens = 0; ovl = 0; en_first = -1; en_last = -1; sod_c = -1; eod_c = -1;
    b0.delete(); b1.delete(); lens.delete();
  endtask
  task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l, input logic v);
    if0.s_data = d; if0.s_keep = k; if0.s_last = l; if0.s_valid = v;
    if1.s_data = d; if1.s_keep = k; if1.s_last = l; if1.s_valid = v;
  endtask
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    n = 0;
    drive(d, k, l, 1'b1);
    while (!if0.s_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask
  task automatic idle();
    drive('0, '0, 1'b0, 1'b0);
  endtask
  task automatic wait_eods(input int want);
    int n;
    n = 0;
    while (eods < want && n < 300) begin @(posedge clk); #1; n++; end
    chk("eod_count", eods, want);
  endtask
  task automatic chk_b(input string tag, input logic sel, input logic [63:0] w, input int nb, input int off);
    for (int i = 0; i < nb; i++) begin
      logic [7:0]  e;
      logic [31:0] got;
      e = w[8*i +: 8];
      got = 32'hDEAD;
      if (!sel && off + i < b0.size()) got = 32'(b0[off+i]);
      if (sel && off + i < b1.size()) got = 32'(b1[off+i]);
      chk($sformatf("%s[%0d]", tag, off + i), got, 32'(e));
    end
  endtask
  initial begin
    logic [63:0] w;
    int n;
    idle();
    clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {sod0, en0, eod0, if0.s_ready, ch0, len0}, 32'd0);
    rst = 1'b0;
    chk("rdy_low_at_release", if0.s_ready, 32'd0);
    @(posedge clk); #1;
    chk("rdy_after_release", if0.s_ready, 32'd1);
    // single 6-byte word
    clear();
    send(64'h0067_6966_2E31_2F73, 8'h3F, 1'b1);
    idle();
    wait_eods(1);
    chk("t1_sods", sods, 1);
    chk("t1_ens", ens, 6);
    chk_b("t1_byte", 1'b0, 64'h0067_6966_2E31_2F73, 6, 0);
    chk("t1_len", lens[0], 6);
    chk("t1_sod_to_en", en_first, sod_c + 1);
    chk("t1_en_to_eod", eod_c, en_last + 1);
    repeat (4) @(posedge clk);
    #1;
    // three back-to-back full words
    clear();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(8'h80 + 8 * i + j);
      send(w, 8'hFF, i == 2);
    end
    idle();
    wait_eods(1);
    chk("t2_sods", sods, 1);
    chk("t2_ens", ens, 24);
    chk("t2_no_gaps", en_last - en_first, 23);
    chk("t2_len", lens[0], 24);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(8'h80 + 8 * i + j);
      chk_b("t2_byte", 1'b0, w, 8, 8 * i);
    end
    repeat (4) @(posedge clk);
    #1;
    // "UPLOADS/" folded and unfolded
    clear();
    send(64'h2F53_4441_4F4C_5055, 8'hFF, 1'b1);
    idle();
    wait_eods(1);
    chk_b("t3_fold", 1'b0, 64'h2F73_6461_6F6C_7075, 8, 0);
    chk_b("t3_nofold", 1'b1, 64'h2F53_4441_4F4C_5055, 8, 0);
    chk("t3_len", lens[0], 8);
    repeat (4) @(posedge clk);
    #1;
    // empty packet then 2-byte packet, back to back
    clear();
    send(64'h0, 8'h00, 1'b1);
    send(64'h6261, 8'h03, 1'b1);
    idle();
    wait_eods(2);
    chk("t4_sods", sods, 2);
    chk("t4_ens", ens, 2);
    chk("t4_overlap", ovl, 0);
    chk("t4_len0", lens[0], 0);
    chk("t4_len1", lens[1], 2);
    chk("t4_sod_before_en", en_first, sod_c + 1);
    chk_b("t4_byte", 1'b0, 64'h6261, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    // source stall, zero-keep word, non-contiguous keep on last word
    clear();
    send(64'h1716_1514_1312_1110, 8'hFF, 1'b0);
    idle();
    repeat (12) @(posedge clk);
    #1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0);
    send(64'h0000_0000_2322_2120, 8'h0B, 1'b1);
    idle();
    wait_eods(1);
    chk("t5_ens", ens, 10);
    chk("t5_len", lens[0], 10);
    chk("t5_sods", sods, 1);
    chk("t5_stall_gap", 32'((en_last - en_first + 1) > ens), 32'd1);
    chk_b("t5_byte", 1'b0, 64'h1716_1514_1312_1110, 8, 0);
    chk_b("t5_byte", 1'b0, 64'h2120, 2, 8);
    chk("t5_overlap", ovl, 0);
    repeat (4) @(posedge clk);
    #1;
    // reset in the middle of streaming
    clear();
    send(64'h6867_6665_6463_6261, 8'hFF, 1'b1);
    idle();
    n = 0;
    while (ens < 3 && n < 50) begin @(posedge clk); #1; n++; end
    chk("t6_streaming", 32'(ens >= 3), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_outputs", {sod0, en0, eod0, if0.s_ready, ch0, len0}, 32'd0);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("t6_no_eod", eods, 0);
    clear();
    send(64'h7A, 8'h01, 1'b1);
    idle();
    wait_eods(1);
    chk("t6_sods", sods, 1);
    chk("t6_ens", ens, 1);
    chk("t6_len", lens[0], 1);
    chk("t6_clean_sod", en_first, sod_c + 1);
    chk_b("t6_byte", 1'b0, 64'h7A, 1, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
